// File: rtl/spd_pkg.sv
// Shared types, constants and saturation helpers for the speed command generator.
package spd_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        CRUISE    = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    // Heading error is clipped to the 10-bit signed range before any arithmetic.
    localparam logic signed [11:0] ERR_SAT_MAX = 12'sd511;
    localparam logic signed [11:0] ERR_SAT_MIN = -12'sd512;

    // 13-bit signed -> 12-bit signed, clamped to [-2048, 2047].
    function automatic logic signed [11:0] sat12(input logic signed [12:0] v);
        if (v > 13'sd2047)
            return 12'sh7FF;
        else if (v < -13'sd2048)
            return 12'sh800;
        else
            return v[11:0];
    endfunction

    // Same clamp for the wider steering sum (the optional D term can push it past 13 bits).
    function automatic logic signed [11:0] sat12w(input logic signed [15:0] v);
        if (v > 16'sd2047)
            return 12'sh7FF;
        else if (v < -16'sd2048)
            return 12'sh800;
        else
            return v[11:0];
    endfunction

endpackage

// File: rtl/spd_cmd_gen_pi_term.sv
// Steering term: error saturation, P multiply, saturating integrator, optional D path.
// Optional feature: D_TERM_EN adds a derivative term from a prev_err register.
// pid is combinational and reflects the integrator value this strobe will commit.
module pi_term
    import spd_pkg::*;
#(
    parameter logic signed [3:0] P_COEFF = 4'sd3,
    parameter logic signed [3:0] D_COEFF = 4'sd2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               err_vld,
    input  logic               moving,
    input  logic signed [11:0] error,
    output logic signed [11:0] pid
);

    logic signed [9:0]  err_sat;
    logic signed [13:0] p_term;
    logic signed [16:0] integ_sum;
    logic signed [15:0] integ_q;
    logic signed [15:0] integ_nxt;
    logic signed [11:0] i_term;
    logic signed [15:0] d_term;
    logic signed [15:0] pid_sum;

    // Clip error, form P, and compute the saturating integrator update.
    always_comb begin
        if (error > ERR_SAT_MAX)
            err_sat = 10'sd511;
        else if (error < ERR_SAT_MIN)
            err_sat = 10'sh200;
        else
            err_sat = error[9:0];

        p_term    = 14'(err_sat) * 14'(P_COEFF);
        integ_sum = 17'(integ_q) + 17'(err_sat);

        if (!moving)
            integ_nxt = '0;
        else if (integ_sum > 17'sd32767)
            integ_nxt = 16'sh7FFF;
        else if (integ_sum < -17'sd32768)
            integ_nxt = 16'sh8000;
        else
            integ_nxt = integ_sum[15:0];

        // Arithmetic >>> 4 of a 16-bit value always fits in 12 bits.
        i_term = integ_nxt[15:4];
    end

    // Integrator commits only on a strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            integ_q <= '0;
        else if (err_vld)
            integ_q <= integ_nxt;
    end

`ifdef D_TERM_EN
    logic signed [9:0]  prev_err;
    logic signed [10:0] err_diff;

    // Derivative from the error step since the last strobe.
    always_comb begin
        err_diff = 11'(err_sat) - 11'(prev_err);
        d_term   = 16'(err_diff) * 16'(D_COEFF);
    end

    // prev_err follows err_sat per strobe and is held at 0 while stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prev_err <= '0;
        else if (!moving)
            prev_err <= '0;
        else if (err_vld)
            prev_err <= err_sat;
    end
`else
    // No derivative path in this build.
    always_comb begin
        d_term = '0;
    end
`endif

    // Steering is forced to zero while stopping so deceleration stays straight.
    always_comb begin
        pid_sum = 16'(p_term) + 16'(i_term) + d_term;
        pid     = moving ? sat12w(pid_sum) : 12'sd0;
    end

endmodule

// File: rtl/spd_cmd_gen.sv
// Speed command generator: forward ramp FSM plus PI(D) steering mixed into lft/rght speeds.
// Optional feature: D_TERM_EN (derivative steering term inside pi_term).
module spd_cmd_gen
    import spd_pkg::*;
#(
    parameter logic        [10:0] MAX_FRWRD = 11'h2A0,
    parameter logic        [10:0] FRWRD_INC = 11'h010,
    parameter logic        [10:0] FRWRD_DEC = 11'h020,
    parameter logic signed [3:0]  P_COEFF   = 4'sd3,
    parameter logic signed [3:0]  D_COEFF   = 4'sd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        moving,
    input  logic        err_vld,
    input  logic [11:0] error,
    output logic [11:0] lft_spd,
    output logic [11:0] rght_spd,
    output logic        at_max
);

    state_t             state_q, state_nxt;
    logic [10:0]        frwrd_q, frwrd_nxt;
    logic [11:0]        frwrd_inc;
    logic signed [11:0] pid;
    logic signed [12:0] sum_l, sum_r;

    pi_term #(
        .P_COEFF(P_COEFF),
        .D_COEFF(D_COEFF)
    ) u_pi_term (
        .clk    (clk),
        .rst_n  (rst_n),
        .err_vld(err_vld),
        .moving (moving),
        .error  ($signed(error)),
        .pid    (pid)
    );

    // Ramp state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_nxt;
    end

    // Ramp state transitions, evaluated every clock on the committed forward speed.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:      if (moving) state_nxt = RAMP_UP;
            RAMP_UP:   if (!moving) state_nxt = RAMP_DOWN;
                       else if (frwrd_q == MAX_FRWRD) state_nxt = CRUISE;
            CRUISE:    if (!moving) state_nxt = RAMP_DOWN;
            RAMP_DOWN: if (moving) state_nxt = RAMP_UP;
                       else if (frwrd_q == '0) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Next forward speed and output mix; the ramp follows moving directly so the
    // very first strobe after moving rises already takes a step.
    always_comb begin
        frwrd_inc = {1'b0, frwrd_q} + {1'b0, FRWRD_INC};
        if (state_q == IDLE && !moving)
            frwrd_nxt = '0;
        else if (moving)
            frwrd_nxt = (frwrd_inc > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : frwrd_inc[10:0];
        else
            frwrd_nxt = (frwrd_q > FRWRD_DEC) ? frwrd_q - FRWRD_DEC : 11'd0;

        sum_l = $signed({2'b00, frwrd_nxt}) + 13'(pid);
        sum_r = $signed({2'b00, frwrd_nxt}) - 13'(pid);
    end

    // Forward speed and registered outputs advance once per strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frwrd_q  <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
            at_max   <= 1'b0;
        end else if (err_vld) begin
            frwrd_q  <= frwrd_nxt;
            lft_spd  <= sat12(sum_l);
            rght_spd <= sat12(sum_r);
            at_max   <= (frwrd_nxt == MAX_FRWRD);
        end
    end

endmodule

// File: tb/tb_spd_cmd_gen.sv
// Self-checking bench for spd_cmd_gen: integer reference model checked every cycle,
// directed literal checks, then randomized moving/error/strobe traffic.
// Honors D_TERM_EN when the build defines it.
module tb_spd_cmd_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        moving = 1'b0;
    logic        err_vld = 1'b0;
    logic [11:0] error = '0;
    logic [11:0] lft_spd, rght_spd;
    logic        at_max;

    int n_cmp = 0;
    int n_fail = 0;

    // Model state (expected registered outputs and internal quantities).
    int m_f = 0, m_ig = 0, m_l = 0, m_r = 0;
    bit m_am = 1'b0;
`ifdef D_TERM_EN
    int m_pe = 0;
`endif

    spd_cmd_gen dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .moving  (moving),
        .err_vld (err_vld),
        .error   (error),
        .lft_spd (lft_spd),
        .rght_spd(rght_spd),
        .at_max  (at_max)
    );

    always #5 clk = ~clk;

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Reference model written straight from the arithmetic rules.
    always @(posedge clk or negedge rst_n) begin : model
        int es, ig, f, p, i, d, pid;
        if (!rst_n) begin
            m_f <= 0; m_ig <= 0; m_l <= 0; m_r <= 0; m_am <= 1'b0;
`ifdef D_TERM_EN
            m_pe <= 0;
`endif
        end else begin
            if (err_vld) begin
                es = clamp($signed(error), -512, 511);
                if (moving) begin
                    f   = (m_f + 16 > 672) ? 672 : m_f + 16;
                    ig  = clamp(m_ig + es, -32768, 32767);
                    p   = es * 3;
                    i   = ig >>> 4;
                    d   = 0;
`ifdef D_TERM_EN
                    d   = (es - m_pe) * 2;
`endif
                    pid = clamp(p + i + d, -2048, 2047);
                end else begin
                    f   = (m_f < 32) ? 0 : m_f - 32;
                    ig  = 0;
                    pid = 0;
                end
                m_f  <= f;
                m_ig <= ig;
                m_l  <= clamp(f + pid, -2048, 2047);
                m_r  <= clamp(f - pid, -2048, 2047);
                m_am <= (f == 672);
            end
`ifdef D_TERM_EN
            if (!moving) m_pe <= 0;
            else if (err_vld) m_pe <= clamp($signed(error), -512, 511);
`endif
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        chk("lft_vs_model", $signed(lft_spd), m_l);
        chk("rght_vs_model", $signed(rght_spd), m_r);
        chk("at_max_vs_model", int'(at_max), int'(m_am));
    end

    task automatic step(input bit mv, input bit ev, input logic [11:0] e);
        moving  = mv;
        err_vld = ev;
        error   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input int l, input int r, input int am);
        chk({nm, "_lft"}, int'(lft_spd), l);
        chk({nm, "_rght"}, int'(rght_spd), r);
        chk({nm, "_at_max"}, int'(at_max), am);
    endtask

    initial begin
        bit mv;
        int mode;
        logic [11:0] e;

        // Reset held with strobes: everything stays zero.
        repeat (3) step(1'b0, 1'b1, 12'h100);
        chk_out("reset", 0, 0, 0);
        #2 rst_n = 1'b1;
        repeat (4) step(1'b0, 1'b1, 12'($urandom));
        chk_out("idle_hold", 0, 0, 0);

        // Ramp to cruise in 42 strobes, then no overshoot.
        repeat (41) step(1'b1, 1'b1, 12'h000);
        chk_out("ramp41", 'h290, 'h290, 0);
        step(1'b1, 1'b1, 12'h000);
        chk_out("ramp42", 'h2A0, 'h2A0, 1);
        repeat (3) step(1'b1, 1'b1, 12'h000);
        chk_out("no_overshoot", 'h2A0, 'h2A0, 1);

        // Steering with integrator at 0.
        step(1'b1, 1'b1, 12'h040);
        chk_out("steer", 'h364, 'h1DC, 1);

        // Held strobe-less cycles keep outputs.
        repeat (3) step(1'b1, 1'b0, 12'h7FF);
        chk_out("hold", 'h364, 'h1DC, 1);

        // Fresh ramp, then saturating error.
        repeat (25) step(1'b0, 1'b1, 12'h000);
        chk_out("drain", 0, 0, 0);
        repeat (42) step(1'b1, 1'b1, 12'h000);
        step(1'b1, 1'b1, 12'h7FF);
        chk_out("sat", 'h7FF, 'hC84, 1);

        // Stop from cruise: straight deceleration by 0x20.
        step(1'b0, 1'b1, 12'h100);
        chk_out("stop1", 'h280, 'h280, 0);
        repeat (20) step(1'b0, 1'b1, 12'h100);
        chk_out("stop21", 0, 0, 0);

        // Async reset mid-ramp.
        repeat (10) step(1'b1, 1'b1, 12'h000);
        chk_out("pre_rst", 'h0A0, 'h0A0, 0);
        #2 rst_n = 1'b0;
        #1 chk_out("async_rst", 0, 0, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 1'b1, 12'h000);
        chk_out("post_rst", 'h010, 'h010, 0);

`ifdef D_TERM_EN
        repeat (41) step(1'b1, 1'b1, 12'h000);
        step(1'b1, 1'b1, 12'h020);
        chk_out("d_step", 'h342, 'h1FE, 1);
        step(1'b1, 1'b1, 12'h020);
        chk_out("d_flat", 'h304, 'h23C, 1);
`endif

        // Randomized traffic: segments with different error flavours.
        for (int seg = 0; seg < 30; seg++) begin
            mv   = (seg % 5) != 4;
            mode = $urandom_range(0, 3);
            for (int k = 0; k < 100; k++) begin
                if ($urandom_range(0, 39) == 0) mv = ~mv;
                case (mode)
                    0:       e = 12'($urandom);
                    1:       e = 12'($urandom_range(0, 63)) - 12'd32;
                    2:       e = 12'h600 + 12'($urandom_range(0, 511));
                    default: e = 12'h900 - 12'($urandom_range(0, 511));
                endcase
                step(mv, $urandom_range(0, 3) != 0, e);
                if (seg == 17 && k == 50) begin
                    #2 rst_n = 1'b0;
                    #1 chk_out("rand_rst", 0, 0, 0);
                    @(negedge clk);
                    #1 rst_n = 1'b1;
                end
            end
        end

        err_vld = 1'b0;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
